// File: rtl/router_stat_pkg.sv
// Shared types and tag-kind decoding for the router stat trigger.
package router_stat_pkg;

   localparam int unsigned TAG_W    = 32;
   localparam int unsigned KIND_MSB = 31;
   localparam int unsigned KIND_LSB = 30;

   localparam logic [1:0] KIND_START = 2'b10;
   localparam logic [1:0] KIND_END   = 2'b11;

   typedef enum logic [1:0] {GENERIC, KERNEL_START, KERNEL_END} stat_kind_e;

   typedef enum logic {ST_IDLE, ST_ACTIVE} trig_state_e;

   // Classify a print-stat tag by its two kind bits.
   function automatic stat_kind_e decode_kind(input logic [TAG_W-1:0] tag);
      logic [1:0] w_kind_bits;
      w_kind_bits = tag[KIND_MSB:KIND_LSB];
      case (w_kind_bits)
         KIND_START: decode_kind = KERNEL_START;
         KIND_END:   decode_kind = KERNEL_END;
         default:    decode_kind = GENERIC;
      endcase
   endfunction

endpackage

// File: rtl/router_stat_tag_fifo.sv
// Small 1r1w tag FIFO with full/empty flags; pushes while full are dropped.
module router_stat_tag_fifo
   import router_stat_pkg::*;
#(
   parameter int unsigned els_p = 4
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             push_i,
   input  logic [TAG_W-1:0] data_i,
   input  logic             pop_i,
   output logic [TAG_W-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int unsigned CNT_W = $clog2(els_p + 1);

   logic [TAG_W-1:0] r_mem [els_p];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(els_p - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (r_cnt == CNT_W'(els_p));
   assign empty_o = (r_cnt == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = r_mem[r_rd_ptr];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

endmodule

// File: rtl/router_stat_trigger.sv
// Global cycle counter, paced print-stat broadcast and kernel period ticks.
// ROUTER_STAT_TRIGGER_SATURATE_EN: global counter saturates instead of wrapping.
module router_stat_trigger
   import router_stat_pkg::*;
#(
   parameter int unsigned fifo_els_p  = 4,
   parameter int unsigned period_p    = 250,
   parameter int unsigned min_gap_p   = 2,
   parameter int unsigned ctr_width_p = 32
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   stat_v_i,
   input  logic [TAG_W-1:0]       stat_tag_i,
   output logic                   stat_ready_o,
   output logic                   print_stat_v_o,
   output logic [TAG_W-1:0]       print_stat_tag_o,
   output logic [ctr_width_p-1:0] global_ctr_o,
   output logic                   kernel_active_o,
   output logic                   period_tick_o
);

   localparam int unsigned     GAP_W      = $clog2(min_gap_p + 1);
   localparam int unsigned     PER_W      = $clog2(period_p + 1);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(min_gap_p - 1);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(period_p - 1);

   logic                   w_push;
   logic                   w_bypass;
   logic                   w_fifo_push;
   logic                   w_fifo_pop;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_gap_zero;
   logic [TAG_W-1:0]       w_head;
   logic [GAP_W-1:0]       r_gap;
   logic                   r_strobe_v;
   logic [TAG_W-1:0]       r_strobe_tag;
   logic [ctr_width_p-1:0] r_ctr;
   trig_state_e            r_state;
   trig_state_e            w_state_nxt;
   logic [PER_W-1:0]       r_pcnt;
   logic [PER_W-1:0]       w_pcnt_nxt;
   logic                   r_tick;
   logic                   w_tick_nxt;
   stat_kind_e             w_kind;

   // An empty buffer with an expired gap forwards the request straight to the strobe.
   assign w_push      = stat_v_i & ~w_full;
   assign w_gap_zero  = (r_gap == '0);
   assign w_fifo_pop  = ~w_empty & w_gap_zero;
   assign w_bypass    = w_empty & w_push & w_gap_zero;
   assign w_fifo_push = w_push & ~w_bypass;

   router_stat_tag_fifo #(
      .els_p(fifo_els_p)
   ) u_fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .push_i   (w_fifo_push),
      .data_i   (stat_tag_i),
      .pop_i    (w_fifo_pop),
      .data_o   (w_head),
      .full_o   (w_full),
      .empty_o  (w_empty)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_strobe_v   <= 1'b0;
         r_strobe_tag <= '0;
         r_gap        <= '0;
      end else begin
         r_strobe_v <= w_fifo_pop | w_bypass;
         if (w_fifo_pop) begin
            r_strobe_tag <= w_head;
            r_gap        <= GAP_RELOAD;
         end else if (w_bypass) begin
            r_strobe_tag <= stat_tag_i;
            r_gap        <= GAP_RELOAD;
         end else if (!w_gap_zero) begin
            r_gap <= r_gap - GAP_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_ctr <= '0;
`ifdef ROUTER_STAT_TRIGGER_SATURATE_EN
      end else if (r_ctr != '1) begin
         r_ctr <= r_ctr + ctr_width_p'(1);
`else
      end else begin
         r_ctr <= r_ctr + ctr_width_p'(1);
`endif
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
         r_pcnt  <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   // Kernel tracking reacts to the strobe being broadcast this cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_pcnt_nxt  = r_pcnt;
      w_tick_nxt  = 1'b0;
      w_kind      = decode_kind(r_strobe_tag);
      case (r_state)
         ST_IDLE: begin
            w_pcnt_nxt = '0;
            if (r_strobe_v && (w_kind == KERNEL_START)) w_state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            w_pcnt_nxt = (r_pcnt == PER_LAST) ? '0 : r_pcnt + PER_W'(1);
            if (r_strobe_v && (w_kind == KERNEL_START)) begin
               w_pcnt_nxt = '0;
            end else if (r_strobe_v && (w_kind == KERNEL_END)) begin
               w_state_nxt = ST_IDLE;
               w_pcnt_nxt  = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_tick_nxt = (w_state_nxt == ST_ACTIVE) && (w_pcnt_nxt == PER_LAST);
   end

   assign stat_ready_o     = ~w_full;
   assign print_stat_v_o   = r_strobe_v;
   assign print_stat_tag_o = r_strobe_tag;
   assign global_ctr_o     = r_ctr;
   assign kernel_active_o  = (r_state == ST_ACTIVE);
   assign period_tick_o    = r_tick;

endmodule

// File: tb/tb_router_stat_trigger.sv
// Scoreboard bench for router_stat_trigger: strobes, kernel edges and ticks.
`timescale 1ns/1ps
module tb_router_stat_trigger;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stat_v;
   logic [31:0] stat_tag;
   logic        stat_ready, pv, active, tick;
   logic [31:0] ptag, gctr;
   logic        ready4, pv4, active4, tick4;
   logic [31:0] ptag4;
   logic [3:0]  gctr4;

   int total = 0;
   int bad   = 0;
   int cyc;

   typedef struct packed {logic [31:0] tag; logic [31:0] at;} strobe_t;
   strobe_t q_strobe[$];
   int      q_tick[$];
   int      q_act[$];

   always #5 clk = ~clk;

   router_stat_trigger #(
      .fifo_els_p(4), .period_p(4), .min_gap_p(2), .ctr_width_p(32)
   ) u_dut (
      .clk_i(clk), .reset_n_i(reset_n), .stat_v_i(stat_v), .stat_tag_i(stat_tag),
      .stat_ready_o(stat_ready), .print_stat_v_o(pv), .print_stat_tag_o(ptag),
      .global_ctr_o(gctr), .kernel_active_o(active), .period_tick_o(tick)
   );

   router_stat_trigger #(
      .fifo_els_p(2), .period_p(1), .min_gap_p(1), .ctr_width_p(4)
   ) u_dut4 (
      .clk_i(clk), .reset_n_i(reset_n), .stat_v_i(1'b0), .stat_tag_i(32'h0),
      .stat_ready_o(ready4), .print_stat_v_o(pv4), .print_stat_tag_o(ptag4),
      .global_ctr_o(gctr4), .kernel_active_o(active4), .period_tick_o(tick4)
   );

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] got);
      total++;
      bad++;
      $display("FAIL %s: unexpected event, value %0h at cycle %0d", name, got, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT presents an event.
   logic [31:0] last_tag;
   logic        prev_act;
   strobe_t     e;
   always @(negedge clk) begin
      if (!reset_n) begin
         last_tag = '0;
         prev_act = 1'b0;
      end else begin
         chk("global_ctr", 64'(gctr), 64'(cyc));
`ifdef ROUTER_STAT_TRIGGER_SATURATE_EN
         chk("ctr4_saturate", 64'(gctr4), 64'((cyc > 15) ? 15 : cyc));
`else
         chk("ctr4_wrap", 64'(gctr4), 64'(cyc % 16));
`endif
         chk("idle_instance_quiet", 64'({ready4, pv4, active4, tick4, ptag4}), 64'({4'b1000, 32'h0}));
         if (pv) begin
            if (q_strobe.size() == 0) unexpected("stray_strobe", 64'(ptag));
            else begin
               e = q_strobe.pop_front();
               chk("strobe_tag", 64'(ptag), 64'(e.tag));
               chk("strobe_cycle", 64'(cyc), 64'(e.at));
            end
            last_tag = ptag;
         end else begin
            chk("tag_hold", 64'(ptag), 64'(last_tag));
         end
         if (active !== prev_act) begin
            if (q_act.size() == 0) unexpected("stray_active_edge", 64'(active));
            else chk("active_edge_cycle", 64'(cyc), 64'(q_act.pop_front()));
            prev_act = active;
         end
         if (tick) begin
            if (q_tick.size() == 0) unexpected("stray_tick", 64'(cyc));
            else chk("tick_cycle", 64'(cyc), 64'(q_tick.pop_front()));
         end
      end
   end

   task automatic go_cycle(input int n);
      int guard = 0;
      while (cyc < n && guard < 500) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // exp_at < 0: the request is expected to be discarded by a later reset.
   task automatic push_at(input int n, input logic [31:0] tag, input int exp_at);
      go_cycle(n);
      chk("ready_before_push", 64'(stat_ready), 64'(1));
      stat_v   = 1'b1;
      stat_tag = tag;
      if (exp_at >= 0) q_strobe.push_back({tag, 32'(exp_at)});
      @(negedge clk);
      stat_v = 1'b0;
   endtask

   task automatic reset_now();
      #2 reset_n = 1'b0;
      #1;
      chk("reset_strobe", 64'({pv, ptag}), 64'(0));
      chk("reset_ctr", 64'(gctr), 64'(0));
      chk("reset_flags", 64'({active, tick, stat_ready}), 64'(3'b001));
      chk("pending_before_reset", 64'(q_strobe.size() + q_tick.size() + q_act.size()), 64'(0));
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
   endtask

   int stall_at;
   int waits;

   initial begin
      reset_n  = 1'b0;
      stat_v   = 1'b0;
      stat_tag = '0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);

      // Idle after release: counter runs, buffer ready, no strobes.
      for (int i = 0; i < 10; i++) begin
         chk("ready_idle", 64'(stat_ready), 64'(1));
         @(negedge clk);
      end
      reset_now();

      q_act  = {7, 43, 52};
      q_tick = {10, 14, 18, 22, 26, 30, 34, 38, 42, 55, 59, 63};
      push_at(5, 32'h8000_0000, 6);

      // Back-to-back generic tags: backlog fills, strobes paced two apart.
      go_cycle(20);
      stall_at = -1;
      for (int i = 0; i < 9; i++) begin
         waits = 0;
         while (!stat_ready && waits < 10) begin
            if (stall_at < 0) stall_at = cyc;
            stat_v = 1'b0;
            @(negedge clk);
            waits++;
         end
         if (waits >= 10) unexpected("burst_ready_timeout", 64'(i));
         stat_v   = 1'b1;
         stat_tag = 32'h0000_0010 + 32'(i);
         q_strobe.push_back({stat_tag, 32'(21 + 2 * i)});
         if (i == 8) chk("burst_last_accept_cycle", 64'(cyc), 64'(29));
         @(negedge clk);
      end
      stat_v = 1'b0;
      chk("burst_first_stall", 64'(stall_at), 64'(28));
      chk("burst_ready_full", 64'(stat_ready), 64'(0));

      push_at(41, 32'hC000_0001, 42);
      push_at(45, 32'hC000_0002, 46);
      push_at(50, 32'h8000_0003, 51);

      for (int i = 0; i < 6; i++)
         push_at(60 + i, 32'h0000_0100 + 32'(i), (i < 3) ? 61 + 2 * i : -1);
      reset_now();

      go_cycle(12);
      chk("queues_drained", 64'(q_strobe.size() + q_tick.size() + q_act.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
